// File: rtl/note_recorder.sv
// note_recorder: captures a live note stream into 12-bit {note, duration} song words.
// Define NOTE_RECORDER_MERGE_EN to merge repeated same-note selections into one word.
module note_recorder #(
  parameter int SONG_ADDR_BITS = 5,
  parameter int MAX_DURATION = 63
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                song,
  input  logic                      start,
  input  logic                      stop,
  input  logic [5:0]                note_in,
  input  logic                      note_valid,
  input  logic                      beat,
  output logic                      wr_en,
  output logic [SONG_ADDR_BITS+1:0] wr_addr,
  output logic [11:0]               wr_data,
  output logic                      recording,
  output logic                      done,
  output logic [SONG_ADDR_BITS-1:0] word_count
);
  localparam int N = SONG_ADDR_BITS;
  localparam logic [N-1:0] LAST = '1;
  localparam logic [N-1:0] PENULT = {{(N-1){1'b1}}, 1'b0};
  localparam logic [5:0] MAXD = 6'(MAX_DURATION);
  typedef enum logic [2:0] {IDLE, ARMED, RECORD, FLUSH, TERM, DONE} state_t;
  state_t state, state_n;
  logic [1:0] song_l, song_n;
  logic [5:0] cur_note, cur_n, dur, dur_n, capped, note_dur;
  logic [6:0] dur_inc;
  logic [N-1:0] index, idx_n, wc_n;
  logic sat, same, close, we;
  logic [11:0] wd;
  assign dur_inc = {1'b0, dur} + 7'(beat);
  assign sat = dur_inc > {1'b0, MAXD};
  assign capped = sat ? MAXD : dur_inc[5:0];
  assign note_dur = capped == 6'd0 ? 6'd1 : capped;
`ifdef NOTE_RECORDER_MERGE_EN
  assign same = note_in == cur_note;
`else
  assign same = 1'b0;
`endif
  assign close = note_valid && !same && !stop;
  assign recording = state == ARMED || state == RECORD;
  always_comb begin
    state_n = state;
    song_n = song_l;
    cur_n = cur_note;
    dur_n = dur;
    idx_n = index;
    wc_n = word_count;
    we = 1'b0;
    wd = '0;
    case (state)
      IDLE: if (start) begin
        song_n = song;
        idx_n = '0;
        wc_n = '0;
        state_n = ARMED;
      end
      ARMED: if (stop) state_n = TERM;
        else if (note_valid) begin
          cur_n = note_in;
          dur_n = '0;
          state_n = RECORD;
        end
      RECORD: begin
        // a saturating beat splits the note; stop still credits it, then flushes the rest
        we = stop ? sat : (close || sat);
        wd = {cur_note, note_dur};
        cur_n = close ? note_in : cur_note;
        dur_n = close ? 6'd0 : sat ? 6'd1 : dur_inc[5:0];
        state_n = (we && index == PENULT) ? TERM : stop ? FLUSH : RECORD;
      end
      FLUSH: begin
        we = 1'b1;
        wd = {cur_note, dur == 6'd0 ? 6'd1 : dur};
        state_n = TERM;
      end
      TERM: begin
        we = 1'b1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (we && state != TERM) begin
      idx_n = index + 1'b1;
      wc_n = word_count == LAST ? word_count : word_count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      song_l <= '0;
      cur_note <= '0;
      dur <= '0;
      index <= '0;
      word_count <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      song_l <= song_n;
      cur_note <= cur_n;
      dur <= dur_n;
      index <= idx_n;
      word_count <= wc_n;
      wr_en <= we;
      wr_addr <= {song_l, index};
      wr_data <= wd;
      done <= state == DONE;
    end
  end
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed checks of note_recorder write stream, full-slot handling and reset.
module tb_note_recorder;
  logic clk = 0, reset = 1, start = 0, stop = 0, note_valid = 0, beat = 0;
  logic [1:0] song = 0;
  logic [5:0] note_in = 0;
  logic wr_en, recording, done;
  logic [6:0] wr_addr;
  logic [11:0] wr_data;
  logic [4:0] word_count;
  int total = 0, bad = 0, dcnt = 0;
  logic [6:0] la[$];
  logic [11:0] ld[$];
  note_recorder dut (
    .clk(clk), .reset(reset), .song(song), .start(start), .stop(stop),
    .note_in(note_in), .note_valid(note_valid), .beat(beat), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .recording(recording), .done(done),
    .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
    end
    if (done) dcnt++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input logic [1:0] s);
    la.delete();
    ld.delete();
    song = s;
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic nv(input int n);
    note_in = 6'(n);
    note_valid = 1;
    cyc();
    note_valid = 0;
  endtask
  task automatic beats(input int k);
    beat = 1;
    cyc(k);
    beat = 0;
  endtask
  task automatic halt();
    stop = 1;
    cyc();
    stop = 0;
  endtask
  task automatic wait_done(input int target);
    int t = 0;
    while (dcnt < target && t < 50) begin
      cyc();
      t++;
    end
    chk("done_seen", dcnt, target);
    cyc(2);
  endtask
  initial begin
    int maxa;
    cyc(2);
    reset = 0;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_recording", recording, 0);
    chk("rst_done", done, 0);
    chk("rst_word_count", word_count, 0);
    cyc();
    go(2);
    chk("armed_recording", recording, 1);
    nv(20); beats(3); nv(0); beats(2); halt();
    wait_done(1);
    chk("t1_writes", la.size(), 3);
    chk("t1_a0", la[0], 'h40); chk("t1_d0", ld[0], 'h503);
    chk("t1_a1", la[1], 'h41); chk("t1_d1", ld[1], 'h002);
    chk("t1_a2", la[2], 'h42); chk("t1_d2", ld[2], 0);
    chk("t1_wc", word_count, 2);
    chk("t1_idle_rec", recording, 0);
    go(1);
    nv(7); beats(70); halt();
    wait_done(2);
    chk("t2_writes", la.size(), 3);
    chk("t2_d0", ld[0], 511); chk("t2_d1", ld[1], 455); chk("t2_d2", ld[2], 0);
    chk("t2_a2", la[2], 'h22);
    chk("t2_wc", word_count, 2);
    go(0);
    nv(5); beats(4);
    beat = 1; note_in = 9; note_valid = 1; cyc(); beat = 0; note_valid = 0;
    beats(2); halt();
    wait_done(3);
    chk("t3_writes", la.size(), 3);
    chk("t3_d0", ld[0], 325); chk("t3_d1", ld[1], 578);
    go(0);
    for (int i = 0; i < 40; i++) begin
      nv(i + 1);
      beats(1);
    end
    halt();
    wait_done(4);
    cyc(5);
    chk("t4_writes", la.size(), 32);
    maxa = 0;
    foreach (la[i]) if (la[i] > maxa) maxa = la[i];
    chk("t4_max_addr", maxa, 31);
    chk("t4_d0", ld[0], 65);
    chk("t4_d30", ld[30], 1985);
    chk("t4_a31", la[31], 31); chk("t4_d31", ld[31], 0);
    chk("t4_wc", word_count, 31);
    chk("t4_done_once", dcnt, 4);
    go(1);
    halt();
    wait_done(5);
    chk("t5_writes", la.size(), 1);
    chk("t5_a0", la[0], 'h20); chk("t5_d0", ld[0], 0);
    chk("t5_wc", word_count, 0);
    go(3);
    nv(3); cyc(2);
    reset = 1; cyc(); reset = 0;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_rec", recording, 0);
    chk("mid_rst_wc", word_count, 0);
    cyc(10);
    chk("mid_rst_writes", la.size(), 0);
    chk("mid_rst_done", dcnt, 5);
    go(3);
    nv(12); beats(2); nv(12); beats(3); halt();
    wait_done(6);
`ifdef NOTE_RECORDER_MERGE_EN
    chk("t6_writes", la.size(), 2);
    chk("t6_d0", ld[0], 773); chk("t6_d1", ld[1], 0);
`else
    chk("t6_writes", la.size(), 3);
    chk("t6_d0", ld[0], 770); chk("t6_d1", ld[1], 771); chk("t6_d2", ld[2], 0);
`endif
    chk("t6_a0", la[0], 'h60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
Captures a live note stream (note selections plus the beat tick) and writes it into song memory in the same 12-bit {note, duration} word format that song_reader consumes. It is the writer side of the song storage interface. It sits beside song_reader in the music_player top and is driven by the same beat_generator tick and MCU song select. Its output is a single-port memory write interface.

Parameters:
- SONG_ADDR_BITS, 5, log2 of words per song slot; a slot holds 2^SONG_ADDR_BITS words, and the last word is reserved for the terminator.
- MAX_DURATION, 63, saturation limit for the duration field, in beats; must be ≤ 63.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- song  input  2  target song slot; latched on start
- start  input  1  one-cycle pulse that arms recording
- stop  input  1  one-cycle pulse that ends recording
- note_in  input  6  note code; 0 = rest
- note_valid  input  1  one-cycle pulse; note_in is a new note
- beat  input  1  one-cycle beat tick
- wr_en  output  1  memory write strobe
- wr_addr  output  2+SONG_ADDR_BITS  {song_latched, index}
- wr_data  output  12  {note[5:0], duration[5:0]}
- recording  output  1  high in ARMED and RECORD
- done  output  1  one-cycle pulse after the terminator is written
- word_count  output  SONG_ADDR_BITS  note words written this take, excluding the terminator

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, recording=0, done=0, word_count=0.
  - State IDLE; internal cur_note=0, dur=0, index=0.
- IDLE:
  - start → latch song, index=0, word_count=0 → ARMED.
  - stop, note_valid and beat are ignored.
- ARMED:
  - note_valid → cur_note=note_in, dur=0 → RECORD.
  - Beats are ignored, so silence before the first note is not recorded.
  - stop → TERM; only the terminator is written and word_count=0.
- RECORD:
  - beat → dur+1.
  - If dur+1 would exceed MAX_DURATION: write {cur_note, MAX_DURATION}, dur restarts at 1 for the same note. This splits a long note into multiple words.
  - note_valid → write {cur_note, max(dur,1)} at index, index+1, then cur_note=note_in, dur=0.
  - Zero-beat notes are recorded with duration 1.
  - beat and note_valid in the same cycle: the beat is credited to the outgoing note before it is written. The new note starts at dur=0.
  - stop → FLUSH. stop has priority over a same-cycle note_valid, which is dropped; a same-cycle beat is still credited.
  - Full: the write that makes index = 2^SONG_ADDR_BITS−1 forces FLUSH→TERM behaviour. The pending note (if any) is dropped, and the terminator goes in the last word.
- FLUSH: write {cur_note, max(dur,1)} → TERM.
- TERM: write 12'h000 at the current index (the terminator: duration 0) → DONE.
- DONE: done=1 for one cycle → IDLE.
- Write timing:
  - Every write is registered: wr_en is high exactly one cycle, in the cycle after the triggering event.
  - wr_addr and wr_data are valid while wr_en=1.
  - At most one write per cycle.
- Split during the note_valid cycle: if a beat saturation split and a note_valid occur in the same cycle, write only the note_valid word, with duration MAX_DURATION.
- word_count increments with each note word and saturates at 2^SONG_ADDR_BITS−1.
- Reset mid-operation returns to IDLE immediately. No terminator is written, and partial memory contents are left as-is.
- start outside IDLE is ignored.

Optional Feature:
- Macro NOTE_RECORDER_MERGE_EN.
- Defined: in RECORD, a note_valid whose note_in equals cur_note does not close the current word. It is treated as a continuation and the duration keeps accumulating. The saturation split still applies.
- Undefined: every note_valid closes the current word, including repeats of the same note.

Test Plan:
- start (song=2), note_valid note=20, 3 beats, note_valid note=0, 2 beats, stop → writes at addr 0x40 = {20,3}, 0x41 = {0,2}, 0x42 = 12'h000; done pulses once; word_count=2.
- note 7 held for 70 beats, then stop → writes {7,63}, then {7,7}, then terminator; word_count=2.
- beat and note_valid(note=9) asserted in the same cycle after 4 beats of note 5 → word {5,5} is written; note 9 starts at dur 0.
- 40 successive notes with 1 beat each (song=0) → addrs 0–30 hold notes, addr 31 = 000; no write above 31; word_count=31; done pulses.
- Assert reset two cycles after a note_valid mid-take → all outputs 0 the next cycle; no terminator is written.
- With NOTE_RECORDER_MERGE_EN: note 12, 2 beats, note_valid note=12, 3 beats, stop → single word {12,5} plus terminator. Without the macro → {12,2}, {12,3}, terminator.
